// File: rtl/dmac_ahb_slave_mem.sv
// ----------------------------------------------------------------------------
// dmac_ahb_slave_mem
//
// AHB-Lite subordinate backed by a word-addressed SRAM. It is the far end of
// DMA channel transfers and also serves as on-chip scratch RAM. Every accepted
// data phase is stretched by WAIT_STATES low cycles of S_HReadyOut.
// Out-of-range, oversized or misaligned accesses get the standard two-cycle
// ERROR response and never touch memory.
//
// Parameters:
//   DEPTH       number of 32-bit words (power of two, >= 4)
//   WAIT_STATES S_HReadyOut-low cycles per accepted data phase (0..15)
//   BASE_ADDR   byte address of word 0
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   S_HSel       subordinate select
//   S_HAddr      byte address
//   S_HTrans     00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//   S_HWrite     1 = write
//   S_HSize      000 byte, 001 half, 010 word
//   S_HWData     write data (little-endian lanes)
//   S_HReady     bus HREADY; address phases are sampled only when high
//   S_HReadyOut  data phase complete
//   S_HResp      00 OKAY, 01 ERROR
//   S_HRData     read data, valid in a completing read data phase
//
// Optional feature macro: DMAC_SLV_RAND_STALL_EN
//   When defined, a 16-bit LFSR adds up to 3 random extra wait cycles per
//   transfer. This exercises the manager's not-ready handling.
// ----------------------------------------------------------------------------
module dmac_ahb_slave_mem #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        S_HSel,
    input  logic [31:0] S_HAddr,
    input  logic [1:0]  S_HTrans,
    input  logic        S_HWrite,
    input  logic [2:0]  S_HSize,
    input  logic [31:0] S_HWData,
    input  logic        S_HReady,
    output logic        S_HReadyOut,
    output logic [1:0]  S_HResp,
    output logic [31:0] S_HRData
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH) << 2;
    localparam bit          HAS_WAIT  = (WAIT_STATES > 0);
    localparam logic [3:0]  WAIT_LOAD = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [3:0]    r_waitCnt;
    logic [AW-1:0] r_index;
    logic          r_write;
    logic [2:0]    r_size;
    logic [1:0]    r_lane;
    logic [31:0]   r_mem [DEPTH];

    logic          w_accept;
    logic          w_canAccept;
    logic          w_takeAddr;
    logic          w_legal;
    logic          w_outOfRange;
    logic          w_badSize;
    logic          w_misaligned;
    logic [31:0]   w_offset;
    logic          w_loadCnt;
    logic          w_stallFirst;
    logic          w_stallMore;
    logic [3:0]    w_byteEn;
    logic [31:0]   w_rdWord;

    // Only NONSEQ and SEQ start a data phase; IDLE and BUSY fall through as
    // zero-wait OKAY without any memory access.
    assign w_accept    = S_HSel & S_HReady & ((S_HTrans == 2'b10) | (S_HTrans == 2'b11));
    assign w_canAccept = (r_state == ST_IDLE) | (r_state == ST_DATA) | (r_state == ST_ERR2);
    assign w_takeAddr  = w_accept & w_canAccept;

    // Addresses below BASE_ADDR wrap to a huge offset, so one unsigned
    // compare catches both ends of the window.
    assign w_offset     = S_HAddr - BASE_ADDR;
    assign w_outOfRange = ({1'b0, w_offset} >= MEM_BYTES);
    assign w_badSize    = (S_HSize > 3'b010);
    assign w_misaligned = ((S_HSize == 3'b001) && S_HAddr[0]) ||
                          ((S_HSize == 3'b010) && (S_HAddr[1:0] != 2'b00));
    assign w_legal      = ~(w_outOfRange | w_badSize | w_misaligned);

`ifdef DMAC_SLV_RAND_STALL_EN
    logic [15:0] r_lfsr;
    logic [1:0]  r_stallCnt;
    logic        w_lfsrFb;

    // Fibonacci LFSR, taps 16,14,13,11. It advances every clock.
    assign w_lfsrFb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsrFb};
        end
    end

    // Counts the random extra cycles already added to the current transfer.
    // A stall taken at accept time (no programmed waits) counts as the first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCnt <= 2'd0;
        end else if (w_loadCnt) begin
            r_stallCnt <= HAS_WAIT ? 2'd0 : {1'b0, w_stallFirst};
        end else if ((r_state == ST_WAIT) && (r_waitCnt == 4'd0) && w_stallMore) begin
            r_stallCnt <= r_stallCnt + 2'd1;
        end
    end

    assign w_stallFirst = r_lfsr[0];
    assign w_stallMore  = r_lfsr[0] & (r_stallCnt != 2'd3);
`else
    assign w_stallFirst = 1'b0;
    assign w_stallMore  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. IDLE, DATA and ERR2 all drive HREADYOUT high, so they
    // are the only states in which a new (possibly pipelined) address phase
    // can be taken.
    always_comb begin
        w_nextState = r_state;
        w_loadCnt   = 1'b0;
        case (r_state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (w_accept) begin
                    if (!w_legal) begin
                        w_nextState = ST_ERR1;
                    end else if (HAS_WAIT || w_stallFirst) begin
                        w_nextState = ST_WAIT;
                        w_loadCnt   = 1'b1;
                    end else begin
                        w_nextState = ST_DATA;
                    end
                end else begin
                    w_nextState = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if ((r_waitCnt == 4'd0) && !w_stallMore) begin
                    w_nextState = ST_DATA;
                end
            end
            ST_ERR1: begin
                w_nextState = ST_ERR2;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // The wait counter is loaded on entry to WAIT and counts down to zero.
    // It holds at zero while random stalls extend the WAIT state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waitCnt <= 4'd0;
        end else if (w_loadCnt) begin
            r_waitCnt <= WAIT_LOAD;
        end else if ((r_state == ST_WAIT) && (r_waitCnt != 4'd0)) begin
            r_waitCnt <= r_waitCnt - 4'd1;
        end
    end

    // Address-phase capture. Illegal accesses are captured too, but ERR
    // states never use the captured values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_index <= '0;
            r_write <= 1'b0;
            r_size  <= 3'b000;
            r_lane  <= 2'b00;
        end else if (w_takeAddr) begin
            r_index <= w_offset[AW+1:2];
            r_write <= S_HWrite;
            r_size  <= S_HSize;
            r_lane  <= S_HAddr[1:0];
        end
    end

    // Byte lanes touched by the captured size and low address bits.
    always_comb begin
        w_byteEn = 4'b0000;
        case (r_size)
            3'b000:  w_byteEn = 4'b0001 << r_lane;
            3'b001:  w_byteEn = r_lane[1] ? 4'b1100 : 4'b0011;
            3'b010:  w_byteEn = 4'b1111;
            default: w_byteEn = 4'b0000;
        endcase
    end

    // The SRAM has no reset. A reset asserted mid data phase forces r_state
    // to IDLE at once, so a pending write is simply never committed.
    always_ff @(posedge clk) begin
        if ((r_state == ST_DATA) && r_write) begin
            for (int b = 0; b < 4; b++) begin
                if (w_byteEn[b]) begin
                    r_mem[r_index][8*b +: 8] <= S_HWData[8*b +: 8];
                end
            end
        end
    end

    // The read is asynchronous, so a read data phase that starts on the edge
    // committing a write to the same word already returns the new data.
    assign w_rdWord = r_mem[r_index];

    // Response outputs depend on the registered state only.
    always_comb begin
        S_HReadyOut = 1'b1;
        S_HResp     = 2'b00;
        S_HRData    = 32'h0000_0000;
        case (r_state)
            ST_WAIT: begin
                S_HReadyOut = 1'b0;
            end
            ST_DATA: begin
                if (!r_write) begin
                    S_HRData = w_rdWord;
                end
            end
            ST_ERR1: begin
                S_HReadyOut = 1'b0;
                S_HResp     = 2'b01;
            end
            ST_ERR2: begin
                S_HResp = 2'b01;
            end
            default: begin
                S_HReadyOut = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_dmac_ahb_slave_mem.sv
// ----------------------------------------------------------------------------
// tb_dmac_ahb_slave_mem
//
// Scoreboard bench for dmac_ahb_slave_mem. Three instances cover
// WAIT_STATES = 0, 2 and 3. They share one bus, and dutSel picks which one is
// selected and observed. The driver issues address phases and pushes the
// expected data-phase response of each accepted transfer into a queue. An
// independent monitor follows the bus, counts low-ready cycles, and compares
// each completed data phase against the front of the queue.
// ----------------------------------------------------------------------------
module tb_dmac_ahb_slave_mem;

    typedef struct {
        string       name;
        logic        err;
        int          waits;
        logic [31:0] rdata;
    } exp_t;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;
    localparam logic [2:0] SZ_B   = 3'b000;
    localparam logic [2:0] SZ_H   = 3'b001;
    localparam logic [2:0] SZ_W   = 3'b010;
    localparam logic [2:0] SZ_DW  = 3'b011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hSel;
    logic [31:0] hAddr;
    logic [1:0]  hTrans;
    logic        hWrite;
    logic [2:0]  hSize;
    logic [31:0] hWData;
    logic [1:0]  dutSel;
    int          curWait;
    logic [31:0] pendWData;

    logic        rdy0, rdy1, rdy2;
    logic [1:0]  resp0, resp1, resp2;
    logic [31:0] rd0, rd1, rd2;
    logic        mReady;
    logic [1:0]  mResp;
    logic [31:0] mRData;

    exp_t        expQ[$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    dmac_ahb_slave_mem #(.DEPTH(256), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .S_HSel(hSel && (dutSel == 2'd0)),
        .S_HAddr(hAddr), .S_HTrans(hTrans), .S_HWrite(hWrite), .S_HSize(hSize),
        .S_HWData(hWData), .S_HReady(rdy0), .S_HReadyOut(rdy0), .S_HResp(resp0),
        .S_HRData(rd0)
    );

    dmac_ahb_slave_mem #(.DEPTH(256), .WAIT_STATES(2), .BASE_ADDR(32'h0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .S_HSel(hSel && (dutSel == 2'd1)),
        .S_HAddr(hAddr), .S_HTrans(hTrans), .S_HWrite(hWrite), .S_HSize(hSize),
        .S_HWData(hWData), .S_HReady(rdy1), .S_HReadyOut(rdy1), .S_HResp(resp1),
        .S_HRData(rd1)
    );

    dmac_ahb_slave_mem #(.DEPTH(256), .WAIT_STATES(3), .BASE_ADDR(32'h0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .S_HSel(hSel && (dutSel == 2'd2)),
        .S_HAddr(hAddr), .S_HTrans(hTrans), .S_HWrite(hWrite), .S_HSize(hSize),
        .S_HWData(hWData), .S_HReady(rdy2), .S_HReadyOut(rdy2), .S_HResp(resp2),
        .S_HRData(rd2)
    );

    // Each instance is alone on its bus, so its own HREADYOUT is its HREADY.
    // The monitor looks at the selected instance only.
    always_comb begin
        mReady = rdy0;
        mResp  = resp0;
        mRData = rd0;
        case (dutSel)
            2'd1: begin mReady = rdy1; mResp = resp1; mRData = rd1; end
            2'd2: begin mReady = rdy2; mResp = resp2; mRData = rd2; end
            default: begin mReady = rdy0; mResp = resp0; mRData = rd0; end
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one address phase and hold it until the subordinate is ready.
    // Write data of the previously accepted transfer rides along.
    task automatic applyStimulus(input logic [1:0] trans, input logic wr, input logic [31:0] addr,
                                 input logic [2:0] size, input logic [31:0] wdata,
                                 input string name, input logic err, input logic [31:0] rdata);
        exp_t e;
        int   guard;
        logic rdy;
        hSel   = 1'b1;
        hTrans = trans;
        hWrite = wr;
        hAddr  = addr;
        hSize  = size;
        hWData = pendWData;
        guard  = 0;
        do begin
            @(negedge clk);
            rdy = mReady;
            @(posedge clk);
            #1;
            guard++;
        end while (!rdy && (guard < 40));
        if (!rdy) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: HReadyOut got 0 expected 1 within 40 cycles", name);
        end
        if (trans[1]) begin
            e.name  = name;
            e.err   = err;
            e.waits = err ? 1 : curWait;
            e.rdata = rdata;
            expQ.push_back(e);
            pendWData = wdata;
        end else begin
            pendWData = 32'hBAD0_BAD0;
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(T_IDLE, 1'b0, 32'h0, SZ_W, 32'h0, "idle", 1'b0, 32'h0);
        end
    endtask

    // Monitor: follows address phases seen on the bus and scores every
    // completed data phase. Cycles with nothing pending must be zero-wait OKAY.
    bit   pending = 1'b0;
    int   lowCnt  = 0;
    bit   lowBad  = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            pending = 1'b0;
            lowCnt  = 0;
            lowBad  = 1'b0;
        end else begin
            if (pending) begin
                if (!mReady) begin
                    lowCnt++;
                    if ((expQ.size() > 0) && (mResp !== (expQ[0].err ? 2'b01 : 2'b00))) begin
                        lowBad = 1'b1;
                    end
                end else if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedPhase: got completed data phase expected none");
                    pending = 1'b0;
                end else begin
                    e = expQ.pop_front();
                    checkOutput({e.name, ".waits"}, lowCnt, e.waits);
                    checkOutput({e.name, ".lowResp"}, {31'b0, lowBad}, 32'h0);
                    checkOutput({e.name, ".resp"}, {30'b0, mResp}, e.err ? 32'h1 : 32'h0);
                    checkOutput({e.name, ".rdata"}, mRData, e.rdata);
                    pending = 1'b0;
                end
            end else begin
                checkOutput("idleReady", {31'b0, mReady}, 32'h1);
                checkOutput("idleResp", {30'b0, mResp}, 32'h0);
            end
            if (mReady && hSel && hTrans[1]) begin
                pending = 1'b1;
                lowCnt  = 0;
                lowBad  = 1'b0;
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        hSel      = 1'b0;
        hAddr     = 32'h0;
        hTrans    = T_IDLE;
        hWrite    = 1'b0;
        hSize     = SZ_W;
        hWData    = 32'h0;
        dutSel    = 2'd0;
        curWait   = 0;
        pendWData = 32'h0;

        #12;
        checkOutput("rstReady0", {31'b0, rdy0}, 32'h1);
        checkOutput("rstResp0", {30'b0, resp0}, 32'h0);
        checkOutput("rstRData0", rd0, 32'h0);
        checkOutput("rstReady2", {31'b0, rdy2}, 32'h1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Zero-wait word write then read of the same word.
        applyStimulus(T_NSEQ, 1'b1, 32'h10, SZ_W, 32'hDEADBEEF, "t1wr", 1'b0, 32'h0);
        applyStimulus(T_NSEQ, 1'b0, 32'h10, SZ_W, 32'h0, "t1rd", 1'b0, 32'hDEADBEEF);
        idleCycles(2);

        // Byte and halfword lane writes over a preloaded word.
        applyStimulus(T_NSEQ, 1'b1, 32'h20, SZ_W, 32'h11223344, "t3pre", 1'b0, 32'h0);
        applyStimulus(T_NSEQ, 1'b1, 32'h21, SZ_B, 32'h00005A00, "t3byte", 1'b0, 32'h0);
        applyStimulus(T_NSEQ, 1'b0, 32'h20, SZ_W, 32'h0, "t3rdB", 1'b0, 32'h11225A44);
        applyStimulus(T_NSEQ, 1'b1, 32'h22, SZ_H, 32'hBEEF0000, "t3half", 1'b0, 32'h0);
        applyStimulus(T_NSEQ, 1'b0, 32'h20, SZ_W, 32'h0, "t3rdH", 1'b0, 32'hBEEF5A44);
        idleCycles(1);

        // Error responses: out of range, misaligned, oversized; memory untouched.
        applyStimulus(T_NSEQ, 1'b0, 32'h400, SZ_W, 32'h0, "t4range", 1'b1, 32'h0);
        applyStimulus(T_NSEQ, 1'b1, 32'h0, SZ_W, 32'hCAFEF00D, "t4pre", 1'b0, 32'h0);
        applyStimulus(T_NSEQ, 1'b1, 32'h2, SZ_W, 32'hFFFFFFFF, "t4misW", 1'b1, 32'h0);
        applyStimulus(T_NSEQ, 1'b1, 32'h1, SZ_H, 32'hFFFFFFFF, "t4misH", 1'b1, 32'h0);
        applyStimulus(T_NSEQ, 1'b1, 32'h0, SZ_DW, 32'hFFFFFFFF, "t4size", 1'b1, 32'h0);
        applyStimulus(T_IDLE, 1'b0, 32'h0, SZ_W, 32'h0, "t4abandon", 1'b0, 32'h0);
        applyStimulus(T_NSEQ, 1'b0, 32'h0, SZ_W, 32'h0, "t4rd0", 1'b0, 32'hCAFEF00D);
        applyStimulus(T_NSEQ, 1'b1, 32'h3FC, SZ_W, 32'h0BADCAFE, "t4lastWr", 1'b0, 32'h0);
        applyStimulus(T_NSEQ, 1'b0, 32'h3FC, SZ_W, 32'h0, "t4lastRd", 1'b0, 32'h0BADCAFE);
        idleCycles(1);

        // Burst write with BUSY cycles in the middle.
        applyStimulus(T_NSEQ, 1'b1, 32'h40, SZ_W, 32'h40404040, "t5beat0", 1'b0, 32'h0);
        applyStimulus(T_BUSY, 1'b1, 32'h44, SZ_W, 32'h0, "t5busy1", 1'b0, 32'h0);
        applyStimulus(T_BUSY, 1'b1, 32'h44, SZ_W, 32'h0, "t5busy2", 1'b0, 32'h0);
        applyStimulus(T_SEQ, 1'b1, 32'h44, SZ_W, 32'h44444444, "t5beat1", 1'b0, 32'h0);
        applyStimulus(T_NSEQ, 1'b0, 32'h40, SZ_W, 32'h0, "t5rd0", 1'b0, 32'h40404040);
        applyStimulus(T_NSEQ, 1'b0, 32'h44, SZ_W, 32'h0, "t5rd1", 1'b0, 32'h44444444);
        idleCycles(3);

        // Two wait states: preload four words, then a 4-beat read burst.
        dutSel  = 2'd1;
        curWait = 2;
        idleCycles(1);
        applyStimulus(T_NSEQ, 1'b1, 32'h0, SZ_W, 32'hA0000000, "t2wr0", 1'b0, 32'h0);
        applyStimulus(T_NSEQ, 1'b1, 32'h4, SZ_W, 32'hA0000001, "t2wr1", 1'b0, 32'h0);
        applyStimulus(T_NSEQ, 1'b1, 32'h8, SZ_W, 32'hA0000002, "t2wr2", 1'b0, 32'h0);
        applyStimulus(T_NSEQ, 1'b1, 32'hC, SZ_W, 32'hA0000003, "t2wr3", 1'b0, 32'h0);
        applyStimulus(T_NSEQ, 1'b0, 32'h0, SZ_W, 32'h0, "t2rd0", 1'b0, 32'hA0000000);
        applyStimulus(T_SEQ, 1'b0, 32'h4, SZ_W, 32'h0, "t2rd1", 1'b0, 32'hA0000001);
        applyStimulus(T_SEQ, 1'b0, 32'h8, SZ_W, 32'h0, "t2rd2", 1'b0, 32'hA0000002);
        applyStimulus(T_SEQ, 1'b0, 32'hC, SZ_W, 32'h0, "t2rd3", 1'b0, 32'hA0000003);
        applyStimulus(T_NSEQ, 1'b0, 32'h404, SZ_W, 32'h0, "t2range", 1'b1, 32'h0);
        idleCycles(3);

        // Three wait states: reset in the middle of a write's wait phase.
        dutSel  = 2'd2;
        curWait = 3;
        idleCycles(1);
        applyStimulus(T_NSEQ, 1'b1, 32'h30, SZ_W, 32'h12345678, "t6pre", 1'b0, 32'h0);
        idleCycles(2);
        hSel   = 1'b1;
        hTrans = T_NSEQ;
        hWrite = 1'b1;
        hAddr  = 32'h30;
        hSize  = SZ_W;
        @(posedge clk);
        #1;
        hSel   = 1'b0;
        hTrans = T_IDLE;
        hWData = 32'h87654321;
        @(posedge clk);
        #1;
        checkOutput("t6waitLow", {31'b0, rdy2}, 32'h0);
        rst_n = 1'b0;
        #1;
        checkOutput("t6rstReady", {31'b0, rdy2}, 32'h1);
        checkOutput("t6rstResp", {30'b0, resp2}, 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        pendWData = 32'h0;
        @(posedge clk);
        #1;
        applyStimulus(T_NSEQ, 1'b0, 32'h30, SZ_W, 32'h0, "t6rd", 1'b0, 32'h12345678);
        idleCycles(3);

        checkOutput("drain", expQ.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
